// File: rtl/canvas_draw_sequencer.sv
// canvas_draw_sequencer: expands brush/clear commands into one frame-buffer write per clock (optional CMD_BUFFER_EN pending slot)
module canvas_draw_sequencer #(
  parameter int CELL_W     = 80,
  parameter int CELL_H     = 60,
  parameter int CELL_SHIFT = 3,
  parameter int MAX_BRUSH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [2:0]  cmd_size,
  input  logic [11:0] cmd_colour,
  output logic        write_en,
  output logic [9:0]  write_x,
  output logic [9:0]  write_y,
  output logic [11:0] write_colour,
  output logic        busy,
  output logic        done
);
  localparam logic [6:0] XMAX = 7'(CELL_W - 1);
  localparam logic [6:0] YMAX = 7'(CELL_H - 1);
  localparam logic [2:0] MB   = 3'(MAX_BRUSH);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state, state_n;
  logic [6:0] cur_x, cur_y, sx, ex, ey;
  logic [11:0] colour;
  logic [36:0] cmd_word, l_cmd;
  logic [1:0] l_op;
  logic [9:0] l_x, l_y;
  logic [2:0] l_size, l_n;
  logic [11:0] l_colour;
  logic [6:0] l_cx, l_cy, l_ex_raw, l_ey_raw, l_ex, l_ey;
  logic launch, l_zero, l_clr, last;
  assign cmd_word = {cmd_op, cmd_x, cmd_y, cmd_size, cmd_colour};
  assign {l_op, l_x, l_y, l_size, l_colour} = l_cmd;
`ifdef CMD_BUFFER_EN
  logic buf_valid;
  logic [36:0] buf_cmd;
  assign cmd_ready = !buf_valid;
  assign launch = state == IDLE && (buf_valid || cmd_valid);
  assign l_cmd = buf_valid ? buf_cmd : cmd_word;
  // pending slot: filled by commands offered while drawing, drained when the FSM returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_cmd   <= '0;
    end else if (cmd_valid && cmd_ready && state != IDLE) begin
      buf_valid <= 1'b1;
      buf_cmd   <= cmd_word;
    end else if (state == IDLE && buf_valid) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign cmd_ready = state == IDLE;
  assign launch = state == IDLE && cmd_valid;
  assign l_cmd = cmd_word;
`endif
  // decode the launching command into a clipped cell rectangle and the next FSM state
  always_comb begin
    l_cx     = 7'(l_x >> CELL_SHIFT);
    l_cy     = 7'(l_y >> CELL_SHIFT);
    l_n      = l_size == 3'd0 ? 3'd1 : (l_size > MB ? MB : l_size);
    l_ex_raw = l_cx + 7'(l_n) - 7'd1;
    l_ey_raw = l_cy + 7'(l_n) - 7'd1;
    l_ex     = l_ex_raw > XMAX ? XMAX : l_ex_raw;
    l_ey     = l_ey_raw > YMAX ? YMAX : l_ey_raw;
    l_clr    = l_op == 2'd1;
    l_zero   = !(l_clr || (l_op == 2'd0 && l_cx <= XMAX && l_cy <= YMAX));
    last     = cur_x == ex && cur_y == ey;
    state_n  = state == IDLE ? (launch ? (l_zero ? DONE : DRAW) : IDLE) :
               state == DRAW ? (last ? DONE : DRAW) : IDLE;
    write_en     = state == DRAW;
    done         = state == DONE;
    busy         = state != IDLE;
    write_x      = {cur_x, {CELL_SHIFT{1'b0}}};
    write_y      = {cur_y, {CELL_SHIFT{1'b0}}};
    write_colour = colour;
  end
  // state register plus row-major cell walker; cursor holds its last cell between commands
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      sx     <= '0;
      ex     <= '0;
      ey     <= '0;
      colour <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && launch && !l_zero) begin
        cur_x  <= l_clr ? 7'd0 : l_cx;
        cur_y  <= l_clr ? 7'd0 : l_cy;
        sx     <= l_clr ? 7'd0 : l_cx;
        ex     <= l_clr ? XMAX : l_ex;
        ey     <= l_clr ? YMAX : l_ey;
        colour <= l_colour;
      end else if (state == DRAW && !last) begin
        cur_x <= cur_x == ex ? sx : cur_x + 7'd1;
        cur_y <= cur_x == ex ? cur_y + 7'd1 : cur_y;
      end
    end
  end
endmodule

// File: tb/tb_canvas_draw_sequencer.sv
// tb_canvas_draw_sequencer: scoreboard bench for canvas_draw_sequencer
module tb_canvas_draw_sequencer;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [9:0] cmd_x = '0, cmd_y = '0;
  logic [2:0] cmd_size = '0;
  logic [11:0] cmd_colour = '0;
  logic cmd_ready, write_en, busy, done;
  logic [9:0] write_x, write_y;
  logic [11:0] write_colour;
  typedef logic [65:0] ev_t;
  ev_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, free_cyc = 0, last_l = 0;
  int last_x = 0, last_y = 0;
  logic [11:0] last_col = '0;

  canvas_draw_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
    .cmd_colour(cmd_colour), .write_en(write_en), .write_x(write_x),
    .write_y(write_y), .write_colour(write_colour), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ev_t ev(int c, bit d, bit w, int x, int y, logic [11:0] col);
    return {32'(c), d, w, 10'(x), 10'(y), col};
  endfunction

  task automatic model(input logic [1:0] op, input int x, input int y, input int sz,
                       input logic [11:0] col, input int acc);
    int cx, cy, n, ex, ey, l, w;
    cx = x / 8; cy = y / 8; w = 0; ex = -1; ey = -1;
    n = sz == 0 ? 1 : (sz > 4 ? 4 : sz);
    l = acc > free_cyc ? acc : free_cyc;
    if (op == 2'd1) begin
      cx = 0; cy = 0; ex = 79; ey = 59;
    end else if (op == 2'd0 && cx < 80 && cy < 60) begin
      ex = cx + n - 1 > 79 ? 79 : cx + n - 1;
      ey = cy + n - 1 > 59 ? 59 : cy + n - 1;
    end
    if (ex >= 0)
      for (int yy = cy; yy <= ey; yy++)
        for (int xx = cx; xx <= ex; xx++) begin
          w++;
          q.push_back(ev(l + w, 1'b0, 1'b1, xx * 8, yy * 8, col));
          last_x = xx * 8; last_y = yy * 8; last_col = col;
        end
    q.push_back(ev(l + w + 1, 1'b1, 1'b0, last_x, last_y, last_col));
    free_cyc = l + w + 2;
    last_l = l;
  endtask

  task automatic send(input logic [1:0] op, input int x, input int y, input int sz,
                      input logic [11:0] col, output int acc);
    cmd_op = op; cmd_x = 10'(x); cmd_y = 10'(y); cmd_size = 3'(sz); cmd_colour = col;
    cmd_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 20000 && acc < 0; t++) begin
      if (cmd_ready) begin
        acc = cyc;
        model(op, x, y, sz, col, acc);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout op=%0d", op);
    end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 20000 && q.size() > 0; t++) @(negedge clk);
    check(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (write_en || done)) begin
      if (q.size() == 0)
        check("extra_event", {32'(cyc), done, write_en, write_x, write_y, write_colour}, ev_t'(0));
      else
        check("event", {32'(cyc), done, write_en, write_x, write_y, write_colour}, q.pop_front());
      check("busy", busy, 1'b1);
    end
  end

  initial begin
    int a, b, c, lb;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_we", write_en, 1'b0);
    check("rst_xy", {write_x, write_y}, 20'd0);
    check("rst_col", write_colour, 12'd0);
    check("rst_busy_done", {busy, done}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    send(2'd0, 16, 24, 2, 12'hF00, a);
    drain("t1_brush2");
    send(2'd0, 632, 472, 4, 12'h0F0, a);
    send(2'd0, 0, 0, 0, 12'h00F, a);
    drain("t2_corner_size0");
    send(2'd0, 640, 0, 3, 12'h123, a);
    send(2'd3, 8, 8, 1, 12'h456, b);
`ifdef CMD_BUFFER_EN
    check("t3_ready_back", b, a + 1);
`else
    check("t3_ready_back", b, a + 2);
`endif
    drain("t3_zero_writes");
    send(2'd1, 0, 0, 0, 12'h0AF, a);
    drain("t4_clear");
    send(2'd1, 0, 0, 0, 12'h555, a);
    for (int t = 0; t < 500 && cyc < a + 100; t++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q.delete();
    check("t5_we", write_en, 1'b0);
    check("t5_ready", cmd_ready, 1'b1);
    check("t5_done", {busy, done}, 2'b00);
    check("t5_xy", {write_x, write_y}, 20'd0);
    reset = 1'b0;
    free_cyc = 0; last_x = 0; last_y = 0; last_col = '0;
    repeat (4) @(negedge clk);
    send(2'd0, 80, 80, 4, 12'hABC, a);
    send(2'd0, 200, 200, 2, 12'hDEF, b);
    lb = last_l;
    check("t6_ready_low", cmd_ready, 1'b0);
    send(2'd0, 300, 100, 3, 12'h321, c);
`ifdef CMD_BUFFER_EN
    check("t6_stall", c, lb + 1);
`endif
    drain("t6_buffered");
    for (int i = 0; i < 6; i++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
           int'($urandom_range(0, 7)), 12'($urandom), a);
    end
    drain("rand");
    repeat (5) @(negedge clk);
    check("final_q", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
